// File: rtl/egr_rrq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : egr_rrq_pkg
//  Description : Shared types and default widths for the EGR Read Request
//                Interface responder. rrq_req_t / rrq_rsp_t carry the request
//                and response payloads at the default widths.
//  Revision    : 1.0  initial release
// ============================================================================
package egr_rrq_pkg;

    localparam int RRQ_ADDR_W    = 20;
    localparam int RRQ_TAG_W     = 8;
    localparam int RRQ_DATA_W    = 64;
    localparam int RRQ_REQ_DEPTH = 4;
    localparam int RRQ_MAX_OUT   = 8;

    typedef struct packed {
        logic [RRQ_ADDR_W-1:0] addr;
        logic [RRQ_TAG_W-1:0]  tag;
    } rrq_req_t;

    typedef struct packed {
        logic [RRQ_TAG_W-1:0]  tag;
        logic [RRQ_DATA_W-1:0] data;
        logic                  err;
    } rrq_rsp_t;

endpackage
`default_nettype wire

// File: rtl/egr_rrq_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : egr_rrq_fifo
//  Description : Type- and depth-parameterised synchronous FIFO with
//                occupancy count, full and empty flags.
//  Ports       : clk, rst_n          clock, async active-low reset
//                push_i/push_data_i  write strobe and payload
//                pop_i/pop_data_o    read strobe and head payload (0 when empty)
//                count_o/full_o/empty_o  occupancy status
//  Revision    : 1.0  initial release
// ============================================================================
module egr_rrq_fifo
    import egr_rrq_pkg::*;
#(
    parameter type T     = logic [7:0],
    parameter int  DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  T                           push_data_i,
    input  logic                       pop_i,
    output T                           pop_data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    T                 mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             w_push;
    logic             w_pop;

    // A push into a full FIFO is legal when the head leaves in the same cycle.
    assign w_pop  = pop_i & (cnt_q != '0);
    assign w_push = push_i & ((cnt_q != FULL_CNT) | w_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q + CNT_W'(w_push) - CNT_W'(w_pop);
        if (w_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (w_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (w_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign empty_o    = (cnt_q == '0);
    assign full_o     = (cnt_q == FULL_CNT);
    assign count_o    = cnt_q;
    assign pop_data_o = empty_o ? T'('0) : mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/egr_rrq_responder.sv
`default_nettype none
// ============================================================================
//  Module      : egr_rrq_responder
//  Description : Read Request Interface responder. Buffers read requests,
//                issues them to the mesh under an outstanding-read limit and
//                returns mesh responses in arrival order.
//  Ports       : rrq_req_*_i/o   requestor request channel (valid/ready)
//                rrq_rsp_*_i/o   requestor response channel (valid/ready)
//                mesh_rd_*_i/o   mesh read issue (valid/stall)
//                mesh_rsp_*_i    mesh response (no backpressure)
//                outstanding_o   inflight reads + buffered responses
//                ovf_err_o       sticky: unsolicited mesh response dropped
//  Revision    : 1.0  initial release
// ============================================================================
module egr_rrq_responder
    import egr_rrq_pkg::*;
#(
    parameter int ADDR_W    = RRQ_ADDR_W,
    parameter int TAG_W     = RRQ_TAG_W,
    parameter int DATA_W    = RRQ_DATA_W,
    parameter int REQ_DEPTH = RRQ_REQ_DEPTH,
    parameter int MAX_OUT   = RRQ_MAX_OUT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         rrq_req_valid_i,
    output logic                         rrq_req_ready_o,
    input  logic [ADDR_W-1:0]            rrq_req_addr_i,
    input  logic [TAG_W-1:0]             rrq_req_tag_i,
    output logic                         rrq_rsp_valid_o,
    input  logic                         rrq_rsp_ready_i,
    output logic [TAG_W-1:0]             rrq_rsp_tag_o,
    output logic [DATA_W-1:0]            rrq_rsp_data_o,
    output logic                         rrq_rsp_err_o,
    output logic                         mesh_rd_valid_o,
    input  logic                         mesh_rd_stall_i,
    output logic [ADDR_W-1:0]            mesh_rd_addr_o,
    output logic [TAG_W-1:0]             mesh_rd_tag_o,
    input  logic                         mesh_rsp_valid_i,
    input  logic [TAG_W-1:0]             mesh_rsp_tag_i,
    input  logic [DATA_W-1:0]            mesh_rsp_data_i,
    input  logic                         mesh_rsp_err_i,
    output logic [$clog2(MAX_OUT+1)-1:0] outstanding_o,
    output logic                         ovf_err_o
);

    localparam int OUT_W  = $clog2(MAX_OUT+1);
    localparam int REQ_CW = $clog2(REQ_DEPTH+1);
    localparam logic [OUT_W-1:0]  MAX_OUT_V = OUT_W'(MAX_OUT);
    localparam logic [REQ_CW-1:0] REQ_LAST  = REQ_CW'(REQ_DEPTH-1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [TAG_W-1:0]  tag;
    } req_t;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
        logic              err;
    } rsp_t;

    req_t              w_req_in, w_req_head;
    rsp_t              w_rsp_in, w_rsp_head;
    logic              w_req_push, w_req_pop, w_req_full, w_req_empty;
    logic              w_rsp_push, w_rsp_pop, w_rsp_full, w_rsp_empty;
    logic [REQ_CW-1:0] w_req_cnt;
    logic [OUT_W-1:0]  w_rsp_cnt;
    logic [OUT_W-1:0]  w_outstanding;
    logic              w_rsp_accept;

    logic [OUT_W-1:0]  inflight_q, inflight_d;
    logic              ready_q,    ready_d;
    logic              ovf_q,      ovf_d;

    // ---------------- request path ----------------
    assign w_req_in   = '{addr: rrq_req_addr_i, tag: rrq_req_tag_i};
    assign w_req_push = rrq_req_valid_i & ready_q;
    assign w_req_pop  = mesh_rd_valid_o & ~mesh_rd_stall_i;

    egr_rrq_fifo #(.T(req_t), .DEPTH(REQ_DEPTH)) u_req_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (w_req_push),
        .push_data_i (w_req_in),
        .pop_i       (w_req_pop),
        .pop_data_o  (w_req_head),
        .count_o     (w_req_cnt),
        .full_o      (w_req_full),
        .empty_o     (w_req_empty)
    );

    // Issue gating uses only registered state, so no input reaches it.
    assign w_outstanding   = inflight_q + w_rsp_cnt;
    assign mesh_rd_valid_o = ~w_req_empty & (w_outstanding < MAX_OUT_V);
    assign mesh_rd_addr_o  = w_req_head.addr;
    assign mesh_rd_tag_o   = w_req_head.tag;

    // ---------------- response path ----------------
    // Responses arriving with nothing in flight are unsolicited and dropped.
    assign w_rsp_accept = mesh_rsp_valid_i & (inflight_q != '0);
    assign w_rsp_push   = w_rsp_accept & ~w_rsp_full;
    assign w_rsp_pop    = rrq_rsp_valid_o & rrq_rsp_ready_i;
    assign w_rsp_in     = '{tag: mesh_rsp_tag_i, data: mesh_rsp_data_i, err: mesh_rsp_err_i};

    egr_rrq_fifo #(.T(rsp_t), .DEPTH(MAX_OUT)) u_rsp_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (w_rsp_push),
        .push_data_i (w_rsp_in),
        .pop_i       (w_rsp_pop),
        .pop_data_o  (w_rsp_head),
        .count_o     (w_rsp_cnt),
        .full_o      (w_rsp_full),
        .empty_o     (w_rsp_empty)
    );

    assign rrq_rsp_valid_o = ~w_rsp_empty;
    assign rrq_rsp_tag_o   = w_rsp_head.tag;
    assign rrq_rsp_data_o  = w_rsp_head.data;
    assign rrq_rsp_err_o   = w_rsp_head.err;

    // ---------------- control state ----------------
    always_comb begin
        inflight_d = inflight_q + OUT_W'(w_req_pop) - OUT_W'(w_rsp_accept);
        ovf_d      = ovf_q | (mesh_rsp_valid_i & (inflight_q == '0));
        // Ready next cycle unless the request FIFO ends this cycle full:
        // it stays full with no pop, or the last slot fills with no pop.
        ready_d    = ~((w_req_full & ~w_req_pop) |
                       (w_req_push & ~w_req_pop & (w_req_cnt == REQ_LAST)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= '0;
            ready_q    <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            ready_q    <= ready_d;
            ovf_q      <= ovf_d;
        end
    end

    assign rrq_req_ready_o = ready_q;
    assign outstanding_o   = w_outstanding;
    assign ovf_err_o       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_egr_rrq_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_egr_rrq_responder
//  Description : Self-checking bench for egr_rrq_responder. A queue-based
//                reference model predicts every output each cycle; directed
//                scenarios are followed by a randomized traffic phase.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_egr_rrq_responder;
    import egr_rrq_pkg::*;

    localparam int ADDR_W    = RRQ_ADDR_W;
    localparam int TAG_W     = RRQ_TAG_W;
    localparam int DATA_W    = RRQ_DATA_W;
    localparam int REQ_DEPTH = RRQ_REQ_DEPTH;
    localparam int MAX_OUT   = RRQ_MAX_OUT;
    localparam int OUT_W     = $clog2(MAX_OUT+1);

    logic              clk;
    logic              rst_n;
    logic              rrq_req_valid_i;
    logic              rrq_req_ready_o;
    logic [ADDR_W-1:0] rrq_req_addr_i;
    logic [TAG_W-1:0]  rrq_req_tag_i;
    logic              rrq_rsp_valid_o;
    logic              rrq_rsp_ready_i;
    logic [TAG_W-1:0]  rrq_rsp_tag_o;
    logic [DATA_W-1:0] rrq_rsp_data_o;
    logic              rrq_rsp_err_o;
    logic              mesh_rd_valid_o;
    logic              mesh_rd_stall_i;
    logic [ADDR_W-1:0] mesh_rd_addr_o;
    logic [TAG_W-1:0]  mesh_rd_tag_o;
    logic              mesh_rsp_valid_i;
    logic [TAG_W-1:0]  mesh_rsp_tag_i;
    logic [DATA_W-1:0] mesh_rsp_data_i;
    logic              mesh_rsp_err_i;
    logic [OUT_W-1:0]  outstanding_o;
    logic              ovf_err_o;

    egr_rrq_responder #(
        .ADDR_W(ADDR_W), .TAG_W(TAG_W), .DATA_W(DATA_W),
        .REQ_DEPTH(REQ_DEPTH), .MAX_OUT(MAX_OUT)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .rrq_req_valid_i  (rrq_req_valid_i),
        .rrq_req_ready_o  (rrq_req_ready_o),
        .rrq_req_addr_i   (rrq_req_addr_i),
        .rrq_req_tag_i    (rrq_req_tag_i),
        .rrq_rsp_valid_o  (rrq_rsp_valid_o),
        .rrq_rsp_ready_i  (rrq_rsp_ready_i),
        .rrq_rsp_tag_o    (rrq_rsp_tag_o),
        .rrq_rsp_data_o   (rrq_rsp_data_o),
        .rrq_rsp_err_o    (rrq_rsp_err_o),
        .mesh_rd_valid_o  (mesh_rd_valid_o),
        .mesh_rd_stall_i  (mesh_rd_stall_i),
        .mesh_rd_addr_o   (mesh_rd_addr_o),
        .mesh_rd_tag_o    (mesh_rd_tag_o),
        .mesh_rsp_valid_i (mesh_rsp_valid_i),
        .mesh_rsp_tag_i   (mesh_rsp_tag_i),
        .mesh_rsp_data_i  (mesh_rsp_data_i),
        .mesh_rsp_err_i   (mesh_rsp_err_i),
        .outstanding_o    (outstanding_o),
        .ovf_err_o        (ovf_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: queued requests, reads in flight, buffered responses.
    rrq_req_t m_req_q[$];
    rrq_rsp_t m_rsp_q[$];
    int       m_inflight;
    bit       m_ready;
    bit       m_ovf;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit m_issue_ok();
        return (m_req_q.size() > 0) && ((m_inflight + m_rsp_q.size()) < MAX_OUT);
    endfunction

    task automatic model_reset();
        m_req_q.delete();
        m_rsp_q.delete();
        m_inflight = 0;
        m_ready    = 1'b0;
        m_ovf      = 1'b0;
    endtask

    task automatic compare_all();
        chk("req_ready", rrq_req_ready_o, m_ready);
        chk("rd_valid", mesh_rd_valid_o, m_issue_ok());
        if (m_req_q.size() > 0) begin
            chk("rd_addr", mesh_rd_addr_o, m_req_q[0].addr);
            chk("rd_tag", mesh_rd_tag_o, m_req_q[0].tag);
        end
        chk("rsp_valid", rrq_rsp_valid_o, m_rsp_q.size() > 0);
        if (m_rsp_q.size() > 0) begin
            chk("rsp_tag", rrq_rsp_tag_o, m_rsp_q[0].tag);
            chk("rsp_data", rrq_rsp_data_o, m_rsp_q[0].data);
            chk("rsp_err", rrq_rsp_err_o, m_rsp_q[0].err);
        end
        chk("outstanding", outstanding_o, m_inflight + m_rsp_q.size());
        chk("ovf_err", ovf_err_o, m_ovf);
    endtask

    // Apply one clock edge worth of protocol rules to the model.
    task automatic model_edge();
        int       inf0 = m_inflight;
        bit       rspv = (m_rsp_q.size() > 0);
        rrq_req_t r;
        rrq_rsp_t s;
        if (m_issue_ok() && !mesh_rd_stall_i) begin
            void'(m_req_q.pop_front());
            m_inflight++;
        end
        if (rrq_req_valid_i && m_ready) begin
            r.addr = rrq_req_addr_i;
            r.tag  = rrq_req_tag_i;
            m_req_q.push_back(r);
        end
        if (rspv && rrq_rsp_ready_i) void'(m_rsp_q.pop_front());
        if (mesh_rsp_valid_i) begin
            if (inf0 > 0) begin
                s.tag  = mesh_rsp_tag_i;
                s.data = mesh_rsp_data_i;
                s.err  = mesh_rsp_err_i;
                m_rsp_q.push_back(s);
                m_inflight--;
            end else begin
                m_ovf = 1'b1;
            end
        end
        m_ready = (m_req_q.size() < REQ_DEPTH);
    endtask

    task automatic set_idle();
        rrq_req_valid_i  = 1'b0;
        rrq_req_addr_i   = '0;
        rrq_req_tag_i    = '0;
        rrq_rsp_ready_i  = 1'b0;
        mesh_rd_stall_i  = 1'b0;
        mesh_rsp_valid_i = 1'b0;
        mesh_rsp_tag_i   = '0;
        mesh_rsp_data_i  = '0;
        mesh_rsp_err_i   = 1'b0;
    endtask

    // Inputs are driven at the falling edge; compare, clock, update model.
    task automatic tick();
        compare_all();
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
    endtask

    initial begin
        int       acc;
        int       iss;
        bit       drained;
        rrq_req_t saved;

        set_idle();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);

        // Reset state, then release: ready rises on the first edge after.
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("ready_after_release", rrq_req_ready_o, 1);

        // Unsolicited response with nothing in flight.
        mesh_rsp_valid_i = 1'b1;
        mesh_rsp_tag_i   = 8'h3C;
        mesh_rsp_data_i  = {$urandom, $urandom};
        tick();
        set_idle();
        chk("unsol_rsp_valid", rrq_rsp_valid_o, 0);
        chk("unsol_ovf", ovf_err_o, 1);
        tick();
        tick();
        chk("unsol_ovf_sticky", ovf_err_o, 1);

        // Single read round trip.
        rrq_req_valid_i = 1'b1;
        rrq_req_addr_i  = 20'h00123;
        rrq_req_tag_i   = 8'h05;
        tick();
        set_idle();
        chk("single_rd_valid", mesh_rd_valid_o, 1);
        chk("single_rd_addr", mesh_rd_addr_o, 20'h00123);
        chk("single_rd_tag", mesh_rd_tag_o, 8'h05);
        tick();
        mesh_rsp_valid_i = 1'b1;
        mesh_rsp_tag_i   = 8'h05;
        mesh_rsp_data_i  = 64'hDEADBEEF;
        tick();
        set_idle();
        chk("single_rsp_valid", rrq_rsp_valid_o, 1);
        chk("single_rsp_data", rrq_rsp_data_o, 64'hDEADBEEF);
        chk("single_out_1", outstanding_o, 1);
        rrq_rsp_ready_i = 1'b1;
        tick();
        set_idle();
        chk("single_out_0", outstanding_o, 0);

        // Outstanding limit: 12 requests, no mesh responses.
        acc = 0;
        iss = 0;
        for (int c = 0; c < 60 && acc < 12; c++) begin
            rrq_req_valid_i = 1'b1;
            rrq_req_addr_i  = ADDR_W'($urandom);
            rrq_req_tag_i   = TAG_W'(acc);
            if (mesh_rd_valid_o && !mesh_rd_stall_i) iss++;
            if (rrq_req_ready_o) acc++;
            tick();
        end
        set_idle();
        for (int c = 0; c < 5; c++) begin
            if (mesh_rd_valid_o) iss++;
            tick();
        end
        chk("limit_accepted", acc, 12);
        chk("limit_issues", iss, 8);
        chk("limit_outstanding", outstanding_o, 8);
        chk("limit_ready", rrq_req_ready_o, 0);
        chk("limit_rd_valid", mesh_rd_valid_o, 0);

        // Backpressure: 8 responses buffered, then drained in order.
        for (int i = 0; i < 8; i++) begin
            mesh_rd_stall_i  = 1'b1;
            mesh_rsp_valid_i = 1'b1;
            mesh_rsp_tag_i   = TAG_W'(i);
            mesh_rsp_data_i  = {$urandom, $urandom};
            mesh_rsp_err_i   = (i % 3 == 1);
            tick();
        end
        set_idle();
        mesh_rd_stall_i = 1'b1;
        chk("bp_buffered", outstanding_o, 8);
        for (int i = 0; i < 8; i++) begin
            mesh_rd_stall_i = 1'b1;
            rrq_rsp_ready_i = 1'b1;
            chk("bp_tag", rrq_rsp_tag_o, i);
            chk("bp_outstanding", outstanding_o, 8 - i);
            tick();
        end
        set_idle();
        chk("bp_out_empty", outstanding_o, 0);

        // Stall: head held for 3 cycles, popped on the 4th.
        saved = m_req_q[0];
        for (int k = 0; k < 3; k++) begin
            mesh_rd_stall_i = 1'b1;
            chk("stall_valid", mesh_rd_valid_o, 1);
            chk("stall_addr", mesh_rd_addr_o, saved.addr);
            chk("stall_tag", mesh_rd_tag_o, saved.tag);
            tick();
        end
        mesh_rd_stall_i = 1'b0;
        chk("stall_addr_pop", mesh_rd_addr_o, saved.addr);
        tick();
        set_idle();
        chk("stall_out_after_pop", outstanding_o, 1);

        // Randomized traffic.
        for (int c = 0; c < 1500; c++) begin
            rrq_req_valid_i  = ($urandom_range(0, 99) < 60);
            rrq_req_addr_i   = ADDR_W'($urandom);
            rrq_req_tag_i    = TAG_W'($urandom);
            mesh_rd_stall_i  = ($urandom_range(0, 99) < 25);
            rrq_rsp_ready_i  = ($urandom_range(0, 99) < 70);
            mesh_rsp_valid_i = (m_inflight > 0) ? ($urandom_range(0, 99) < 55)
                                                : ($urandom_range(0, 99) < 2);
            mesh_rsp_tag_i   = TAG_W'($urandom);
            mesh_rsp_data_i  = {$urandom, $urandom};
            mesh_rsp_err_i   = $urandom_range(0, 1) == 1;
            tick();
        end

        // Drain everything before the mid-run reset scenario.
        drained = 1'b0;
        for (int c = 0; c < 300; c++) begin
            set_idle();
            if (m_req_q.size() == 0 && m_inflight == 0 && m_rsp_q.size() == 0) begin
                drained = 1'b1;
                break;
            end
            rrq_rsp_ready_i = 1'b1;
            if (m_inflight > 0) begin
                mesh_rsp_valid_i = 1'b1;
                mesh_rsp_data_i  = {$urandom, $urandom};
            end
            tick();
        end
        chk("drain_done", drained, 1);

        // Mid-run reset with 3 inflight and 2 queued.
        for (int i = 0; i < 3; i++) begin
            rrq_req_valid_i = 1'b1;
            rrq_req_addr_i  = ADDR_W'($urandom);
            rrq_req_tag_i   = TAG_W'(8'h40 + i);
            tick();
        end
        set_idle();
        tick();
        for (int i = 0; i < 2; i++) begin
            mesh_rd_stall_i = 1'b1;
            rrq_req_valid_i = 1'b1;
            rrq_req_addr_i  = ADDR_W'($urandom);
            rrq_req_tag_i   = TAG_W'(8'h50 + i);
            tick();
        end
        set_idle();
        mesh_rd_stall_i = 1'b1;
        chk("pre_rst_outstanding", outstanding_o, 3);
        chk("pre_rst_rd_valid", mesh_rd_valid_o, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_req_ready", rrq_req_ready_o, 0);
        chk("rst_rsp_valid", rrq_rsp_valid_o, 0);
        chk("rst_rsp_tag", rrq_rsp_tag_o, 0);
        chk("rst_rsp_data", rrq_rsp_data_o, 0);
        chk("rst_rsp_err", rrq_rsp_err_o, 0);
        chk("rst_rd_valid", mesh_rd_valid_o, 0);
        chk("rst_rd_addr", mesh_rd_addr_o, 0);
        chk("rst_rd_tag", mesh_rd_tag_o, 0);
        chk("rst_outstanding", outstanding_o, 0);
        chk("rst_ovf", ovf_err_o, 0);
        model_reset();
        @(negedge clk);
        set_idle();
        tick();
        rst_n = 1'b1;
        tick();
        chk("rel_ready", rrq_req_ready_o, 1);
        chk("rel_outstanding", outstanding_o, 0);

        // A late mesh response after reset is unsolicited.
        mesh_rsp_valid_i = 1'b1;
        mesh_rsp_tag_i   = 8'h41;
        mesh_rsp_data_i  = {$urandom, $urandom};
        tick();
        set_idle();
        chk("late_rsp_ovf", ovf_err_o, 1);
        chk("late_rsp_valid", rrq_rsp_valid_o, 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/egr_rrq_responder.md
# egr_rrq_responder

Read Request Interface responder on the Mesh Read Interface side of EGR. Accepts packet read requests from the Packet Read Controller, buffers and issues them to the mesh read port under an outstanding-read limit, and returns mesh read responses to the requestor in mesh-arrival order. The response buffer is sized to the outstanding limit, so the mesh return path needs no backpressure.

## Interface
- ADDR_W, 20, read address width
- TAG_W, 8, requestor tag width, passed through opaquely
- DATA_W, 64, response data width
- REQ_DEPTH, 4, request FIFO depth (power of 2, ≥2)
- MAX_OUT, 8, maximum reads outstanding; also the response FIFO depth (power of 2)
- clk  in  1  block clock
- rst_n  in  1  asynchronous active-low reset
- rrq_req_valid  in  1  request valid
- rrq_req_ready  out  1  request accepted when valid&ready
- rrq_req_addr  in  ADDR_W  read address
- rrq_req_tag  in  TAG_W  request tag
- rrq_rsp_valid  out  1  response valid
- rrq_rsp_ready  in  1  requestor pops response
- rrq_rsp_tag  out  TAG_W  response tag
- rrq_rsp_data  out  DATA_W  read data
- rrq_rsp_err  out  1  mesh error flag for this response
- mesh_rd_valid  out  1  mesh read issue
- mesh_rd_stall  in  1  mesh cannot take the issue this cycle
- mesh_rd_addr  out  ADDR_W  issued address
- mesh_rd_tag  out  TAG_W  issued tag
- mesh_rsp_valid  in  1  mesh response (no backpressure)
- mesh_rsp_tag / mesh_rsp_data / mesh_rsp_err  in  TAG_W / DATA_W / 1  response payload
- outstanding  out  $clog2(MAX_OUT+1)  inflight + response FIFO occupancy
- ovf_err  out  1  sticky: unsolicited mesh response dropped

## Operation
- Request path: the accepted {addr, tag} is pushed into the request FIFO. rrq_req_ready is a register: 0 in reset, then equals "FIFO not full after this cycle's push/pop".
- Issue: mesh_rd_valid = request FIFO non-empty AND outstanding < MAX_OUT. The head entry drives mesh_rd_addr/tag. Pop occurs when mesh_rd_valid & !mesh_rd_stall.
- inflight counter: +1 on issue, −1 on an accepted mesh response. outstanding = inflight + rsp FIFO count.
- Response path: when mesh_rsp_valid and inflight > 0, {tag, data, err} is pushed into the response FIFO. The FIFO cannot overflow, because outstanding ≤ MAX_OUT. rrq_rsp_* is driven from the FIFO head. Pop occurs on rrq_rsp_valid & rrq_rsp_ready.
- Unsolicited response (mesh_rsp_valid while inflight == 0): dropped, no counter change, ovf_err set until reset.
- Simultaneous events:
  - issue + mesh response: inflight unchanged.
  - response push + requestor pop: rsp count unchanged.
  - request push + issue pop on the same FIFO: occupancy unchanged, legal when full.
- Tags are not checked against issued tags; ordering is mesh-arrival order.

## Timing
- Reset (async assert): all outputs 0; FIFOs empty; counters 0. rrq_req_ready rises on the first clk edge after rst_n deasserts.
- Request accepted at edge N: mesh_rd_valid is high no earlier than cycle N+1.
- Mesh response at edge M: rrq_rsp_valid is high in cycle M+1.
- No combinational path from any input to any output, except rrq_rsp_* from FIFO registers and mesh_rd_valid from the registered count compare.
- Under stall, mesh_rd_valid/addr/tag hold stable until the pop.
- Throughput: one request, one issue and one response per cycle sustained.
- Reset mid-operation discards all queued and inflight state. Late mesh responses after reset count as unsolicited and set ovf_err.

## Structure
- egr_rrq_pkg holds:
  - rrq_req_t {addr, tag}
  - rrq_rsp_t {tag, data, err}
  - default width constants
- Sub-module egr_rrq_fifo: parameterised type/depth sync FIFO with count, full and empty outputs. It is instantiated twice, for requests (REQ_DEPTH) and responses (MAX_OUT).
- Top level holds the inflight counter, issue gating, ovf_err and the ready register.

## Test plan
- Single read: addr 0x00123, tag 0x05 accepted at N → mesh_rd_valid at N+1 with 0x00123/0x05. Mesh response tag 0x05, data 0xDEADBEEF → rrq_rsp_valid next cycle; outstanding goes 1→0 on pop.
- Limit: 12 back-to-back requests, mesh never responds → exactly 8 issues and outstanding = 8. After 4 more requests are queued, rrq_req_ready = 0 and mesh_rd_valid = 0.
- Stall: mesh_rd_stall high 3 cycles with a pending request → mesh_rd_valid/addr/tag stable for 3 cycles, pop on the 4th.
- Backpressure: rrq_rsp_ready low, 8 mesh responses with tags 0..7 → all buffered. With ready raised, tags 0..7 are delivered in order; outstanding decrements once per pop.
- Unsolicited: mesh_rsp_valid with inflight = 0 → no rrq_rsp_valid; ovf_err = 1 and stays high until rst_n.
- Mid-run reset: 3 inflight and 2 queued, rst_n pulsed → all outputs 0 immediately; rrq_req_ready = 1 one edge after release; outstanding = 0.
